// File: rtl/mdu_pkg.sv
// Shared definitions for the sequential multiply/divide unit: op codes,
// FSM state encoding and the divide-by-zero quotient fill.
package mdu_pkg;

  localparam logic [2:0] MDU_MULT  = 3'd0;
  localparam logic [2:0] MDU_MULTU = 3'd1;
  localparam logic [2:0] MDU_DIV   = 3'd2;
  localparam logic [2:0] MDU_DIVU  = 3'd3;
  localparam logic [2:0] MDU_MTHI  = 3'd4;
  localparam logic [2:0] MDU_MTLO  = 3'd5;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_e;

  // Every quotient bit is replicated from this on a divide by zero.
  localparam logic DIV0_LO_BIT = 1'b1;

endpackage

// File: rtl/mdu_core.sv
// Combinational signed/unsigned multiply and divide producing the next
// {hi, lo} pair, including divide-by-zero and signed-overflow handling.
module mdu_core
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi_next,
  output logic [WIDTH-1:0] lo_next
);

  logic signed [2*WIDTH-1:0] a_sx;
  logic signed [2*WIDTH-1:0] b_sx;
  logic signed [2*WIDTH-1:0] prod_s;
  logic        [2*WIDTH-1:0] prod_u;
  logic signed [WIDTH-1:0]   a_s;
  logic signed [WIDTH-1:0]   b_safe_s;
  logic signed [WIDTH-1:0]   quo_s;
  logic signed [WIDTH-1:0]   rem_s;
  logic        [WIDTH-1:0]   b_safe_u;
  logic        [WIDTH-1:0]   quo_u;
  logic        [WIDTH-1:0]   rem_u;
  logic                      div_zero;
  logic                      div_ovf;

  always_comb begin
    a_s      = a;
    a_sx     = {{WIDTH{a[WIDTH-1]}}, a};
    b_sx     = {{WIDTH{b[WIDTH-1]}}, b};
    prod_s   = a_sx * b_sx;
    prod_u   = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

    div_zero = (b == '0);
    div_ovf  = (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == '1);

    // Dividing by one instead of -1 yields exactly lo=a, hi=0 on overflow.
    b_safe_s = (div_zero || div_ovf) ? WIDTH'(1) : b;
    b_safe_u = div_zero ? WIDTH'(1) : b;
    quo_s    = a_s / b_safe_s;
    rem_s    = a_s % b_safe_s;
    quo_u    = a / b_safe_u;
    rem_u    = a % b_safe_u;

    hi_next  = '0;
    lo_next  = '0;
    case (op)
      MDU_MULT:  {hi_next, lo_next} = prod_s;
      MDU_MULTU: {hi_next, lo_next} = prod_u;
      MDU_DIV: begin
        if (div_zero) {hi_next, lo_next} = {a, {WIDTH{DIV0_LO_BIT}}};
        else          {hi_next, lo_next} = {rem_s, quo_s};
      end
      MDU_DIVU: begin
        if (div_zero) {hi_next, lo_next} = {a, {WIDTH{DIV0_LO_BIT}}};
        else          {hi_next, lo_next} = {rem_u, quo_u};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu_seq.sv
// Multi-cycle multiply/divide unit with HI/LO registers. The result is
// computed at issue and held pending until the busy window expires.
module mdu_seq
  import mdu_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  mdu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;
  logic             pend_ld;
  logic [WIDTH-1:0] hi_core;
  logic [WIDTH-1:0] lo_core;
  logic [WIDTH-1:0] hi_pend_p0;
  logic [WIDTH-1:0] lo_pend_p0;

  mdu_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .op     (op),
    .a      (a),
    .b      (b),
    .hi_next(hi_core),
    .lo_next(lo_core)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    pend_ld = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          case (op)
            MDU_MULT, MDU_MULTU: begin
              pend_ld = 1'b1;
              cnt_d   = CNT_W'(MUL_CYCLES);
              state_d = ST_RUN;
            end
            MDU_DIV, MDU_DIVU: begin
              pend_ld = 1'b1;
              cnt_d   = CNT_W'(DIV_CYCLES);
              state_d = ST_RUN;
            end
            MDU_MTHI: hi_d = a;
            MDU_MTLO: lo_d = a;
            default: ;
          endcase
        end
      end
      ST_RUN: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          hi_d    = hi_pend_p0;
          lo_d    = lo_pend_p0;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  // Stage p0: result captured at issue, so later operand changes are harmless.
  always_ff @(posedge clk) begin
    if (pend_ld) begin
      hi_pend_p0 <= hi_core;
      lo_pend_p0 <= lo_core;
    end
  end

  assign busy = (state_q == ST_RUN);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_seq.sv
// Self-checking bench for mdu_seq: directed vector table, hand-written
// multi-cycle sequences and randomized ops against a behavioural model.
module tb_mdu_seq;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int total = 0;
  int bad   = 0;

  mdu_seq #(
    .WIDTH     (W),
    .MUL_CYCLES(5),
    .DIV_CYCLES(10)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .op   (op),
    .a    (a),
    .b    (b),
    .busy (busy),
    .done (done),
    .hi   (hi),
    .lo   (lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [2:0] op;
    logic [31:0] a;
    logic [31:0] b;
    int         cyc;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic following the architectural rules.
  function automatic logic [63:0] model(input logic [2:0] mop, input logic [31:0] ma,
                                        input logic [31:0] mb, input logic [63:0] cur);
    longint sa, sb, q, r;
    logic [63:0] res;
    sa = longint'($signed(ma));
    sb = longint'($signed(mb));
    res = cur;
    case (mop)
      3'd0: begin q = sa * sb; res = q; end
      3'd1: res = {32'b0, ma} * {32'b0, mb};
      3'd2, 3'd3: begin
        if (mb == 32'd0) res = {ma, 32'hFFFF_FFFF};
        else if (mop == 3'd2) begin
          q = sa / sb;
          r = sa % sb;
          res = {r[31:0], q[31:0]};
        end else res = {ma % mb, ma / mb};
      end
      3'd4: res = {ma, cur[31:0]};
      3'd5: res = {cur[63:32], ma};
      default: res = cur;
    endcase
    return res;
  endfunction

  function automatic int model_cyc(input logic [2:0] mop);
    if (mop <= 3'd1) return 5;
    if (mop <= 3'd3) return 10;
    return 0;
  endfunction

  // Called on the negedge where start was sampled high; drops start,
  // scrambles operands and waits for busy to fall.
  task automatic wait_op(input string nm, input int exp_cyc,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int cyc;
    @(negedge clk);
    start = 1'b0;
    a = $urandom;
    b = $urandom;
    cyc = 0;
    while (busy && cyc < 200) begin
      cyc++;
      @(negedge clk);
    end
    chk({nm, ".cycles"}, 64'(cyc), 64'(exp_cyc));
    chk({nm, ".done"}, 64'(done), 64'(exp_cyc > 0));
    chk({nm, ".hi"}, 64'(hi), 64'(exp_hi));
    chk({nm, ".lo"}, 64'(lo), 64'(exp_lo));
  endtask

  task automatic do_op(input string nm, input logic [2:0] o, input logic [31:0] xa,
                       input logic [31:0] xb, input int exp_cyc,
                       input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    @(negedge clk);
    start = 1'b1;
    op = o;
    a = xa;
    b = xb;
    wait_op(nm, exp_cyc, exp_hi, exp_lo);
    @(negedge clk);
    chk({nm, ".done_clr"}, 64'(done), 64'(0));
  endtask

  initial begin
    logic [63:0] m;
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    int          cyc, n_done, n_busy;

    vecs[0]  = '{"mult_neg",   3'd0, 32'hFFFF_FFFD, 32'd7,         5,  32'hFFFF_FFFF, 32'hFFFF_FFEB};
    vecs[1]  = '{"multu_max",  3'd1, 32'hFFFF_FFFF, 32'd2,         5,  32'h0000_0001, 32'hFFFF_FFFE};
    vecs[2]  = '{"div_neg",    3'd2, 32'hFFFF_FFF9, 32'd2,         10, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3]  = '{"divu_zero",  3'd3, 32'd7,         32'd0,         10, 32'h0000_0007, 32'hFFFF_FFFF};
    vecs[4]  = '{"div_ovf",    3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0000_0000, 32'h8000_0000};
    vecs[5]  = '{"div_negb",   3'd2, 32'd7,         32'hFFFF_FFFE, 10, 32'h0000_0001, 32'hFFFF_FFFD};
    vecs[6]  = '{"div_zero",   3'd2, 32'hFFFF_FFF8, 32'd0,         10, 32'hFFFF_FFF8, 32'hFFFF_FFFF};
    vecs[7]  = '{"mult_min",   3'd0, 32'h8000_0000, 32'h8000_0000, 5,  32'h4000_0000, 32'h0000_0000};
    vecs[8]  = '{"divu_big",   3'd3, 32'hFFFF_FFFF, 32'd10,        10, 32'h0000_0005, 32'h1999_9999};
    vecs[9]  = '{"mthi",       3'd4, 32'h0000_CAFE, 32'd9,         0,  32'h0000_CAFE, 32'h1999_9999};
    vecs[10] = '{"mtlo",       3'd5, 32'h0000_BEEF, 32'd9,         0,  32'h0000_CAFE, 32'h0000_BEEF};
    vecs[11] = '{"reserved",   3'd6, 32'd1,         32'd2,         0,  32'h0000_CAFE, 32'h0000_BEEF};

    rst_n = 1'b0;
    start = 1'b0;
    op    = 3'd0;
    a     = '0;
    b     = '0;
    #12;
    chk("reset.busy", 64'(busy), 64'(0));
    chk("reset.done", 64'(done), 64'(0));
    chk("reset.hilo", {hi, lo}, 64'(0));
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i])
      do_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cyc, vecs[i].hi, vecs[i].lo);

    // Start requests while busy must be ignored, including MTHI.
    @(negedge clk);
    start = 1'b1; op = 3'd0; a = 32'd6; b = 32'hFFFF_FFFF;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (busy && cyc < 200) begin
      cyc++;
      if (cyc == 2) begin start = 1'b1; op = 3'd4; a = 32'h1234; end
      else if (cyc == 3) begin start = 1'b1; op = 3'd2; a = 32'd1; b = 32'd1; end
      else start = 1'b0;
      @(negedge clk);
      if (cyc == 2) chk("busy_mthi.hi_held", 64'(hi), 64'h0000_CAFE);
      if (cyc == 3) chk("busy_div.busy", 64'(busy), 64'(1));
    end
    start = 1'b0;
    chk("busy_start.cycles", 64'(cyc), 64'(5));
    chk("busy_start.done", 64'(done), 64'(1));
    chk("busy_start.hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFA);
    @(negedge clk);
    chk("busy_start.no_restart", 64'(busy), 64'(0));
    do_op("mtlo_idle", 3'd5, 32'h55, 32'd0, 0, 32'hFFFF_FFFF, 32'h55);

    // Back-to-back: issue while done is still high.
    @(negedge clk);
    start = 1'b1; op = 3'd1; a = 32'd3; b = 32'd5;
    wait_op("b2b_first", 5, 32'd0, 32'd15);
    start = 1'b1; op = 3'd3; a = 32'd100; b = 32'd7;
    wait_op("b2b_second", 10, 32'd2, 32'd14);

    // Asynchronous reset in the middle of a divide.
    @(negedge clk);
    start = 1'b1; op = 3'd2; a = 32'd100; b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst.busy", 64'(busy), 64'(0));
    chk("arst.done", 64'(done), 64'(0));
    chk("arst.hilo", {hi, lo}, 64'(0));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    n_done = 0;
    n_busy = 0;
    repeat (30) begin
      @(negedge clk);
      if (done) n_done++;
      if (busy) n_busy++;
    end
    chk("arst.no_done", 64'(n_done), 64'(0));
    chk("arst.no_busy", 64'(n_busy), 64'(0));
    chk("arst.hilo_after", {hi, lo}, 64'(0));

    // Randomized ops against the model.
    m = 64'd0;
    for (int k = 0; k < 60; k++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 9))
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = 32'($urandom_range(1, 9));
        3: ra = 32'($urandom_range(0, 99));
        default: ;
      endcase
      m = model(rop, ra, rb, m);
      do_op($sformatf("rand%0d_op%0d", k, rop), rop, ra, rb, model_cyc(rop), m[63:32], m[31:0]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
